priority_arbiter_rr: RTL and testbench

//   Registered round-robin arbiter for WIDTH requesters with valid/ready grant handshake.
//   - Two priority_to_onehot_tree instances (masked and unmasked) select the grant.
//   - A rotating mask gives fair rotation; an optional lock keeps the grant for bursts.
//   - Sits between request sources and a shared resource (bus port, FIFO write side).
//

---
 rtl/priority_arbiter_rr.sv | 218 +++++++++++++++++++++
 tb/tb_priority_arbiter_rr.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/priority_arbiter_rr.sv
// Round-robin arbiter: two lowest-set-bit trees (masked/unmasked) pick a requester, grant is registered.
// Latency: 1 cycle from request to gnt_vld; back-to-back grants with no bubble on transfer.
// Backpressure: grant held stable while gnt_rdy=0; optional lock keeps the grant across transfers.

// Lowest-set-bit to one-hot selector built as a SPLIT-ary tree of group-OR terms.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module priority_to_onehot_tree #(
  parameter int WIDTH          = 32,
  parameter int SPLIT          = 2,
  parameter int IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] oht,
  output logic             vld
);

  // Number of tree levels needed so that SPLIT**LEVELS covers WIDTH.
  function automatic int calc_levels();
    int n;
    int l;
    n = 1;
    l = 0;
    while (n < WIDTH && SPLIT > 1) begin
      n = n * SPLIT;
      l++;
    end
    return (l < 1) ? 1 : l;
  endfunction

  function automatic int calc_pw();
    int n;
    n = 1;
    for (int l = 0; l < calc_levels(); l++) n = n * SPLIT;
    return (n < WIDTH) ? WIDTH : n;
  endfunction

  localparam int LEVELS = calc_levels();
  localparam int PW     = calc_pw();

  assign vld = |req;

  generate
    if (IMPLEMENTATION == 0) begin : g_tree
      logic [PW-1:0] ext;
      logic [PW-1:0] any_l [LEVELS];

      // Group-OR per level, then a bit is blocked by any lower sibling group at any level.
      always_comb begin
        logic blk;
        int   s;
        int   my;
        int   pos;
        blk = 1'b0;
        s   = 1;
        my  = 0;
        pos = 0;
        ext = PW'(req);
        for (int l = 0; l < LEVELS; l++) any_l[l] = '0;
        any_l[0] = ext;
        for (int l = 1; l < LEVELS; l++) begin
          for (int g = 0; g < PW / SPLIT; g++) begin
            for (int k = 0; k < SPLIT; k++) begin
              any_l[l][g] = any_l[l][g] | any_l[l-1][g*SPLIT+k];
            end
          end
        end
        oht = '0;
        for (int i = 0; i < WIDTH; i++) begin
          blk = 1'b0;
          s   = 1;
          for (int l = 0; l < LEVELS; l++) begin
            my  = i / s;
            pos = my % SPLIT;
            for (int k = 0; k < SPLIT; k++) begin
              if (k < pos) blk = blk | any_l[l][my-pos+k];
            end
            s = s * SPLIT;
          end
          oht[i] = req[i] & ~blk;
        end
      end
    end else begin : g_arith
      assign oht = req & (~req + WIDTH'(1));
    end
  endgenerate

endmodule

module priority_arbiter_rr #(
  parameter int WIDTH          = 32,
  parameter int SPLIT          = 2,
  parameter int IMPLEMENTATION = 0,
  parameter int LOCK           = 1,
  localparam int IDX_W         = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_vld,
  input  logic [WIDTH-1:0] req_lck,
  output logic [WIDTH-1:0] gnt_oht,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  input  logic             gnt_rdy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] msk_q, msk_d;
  logic [WIDTH-1:0] gnt_oht_q, gnt_oht_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_vld_q, gnt_vld_d;

  logic             xfer;
  logic             locked;
  logic             rearb;
  logic [WIDTH-1:0] msk_nxt;
  logic [WIDTH-1:0] msk_use;
  logic [WIDTH-1:0] req_use;
  logic [WIDTH-1:0] req_msk;
  logic [WIDTH-1:0] msk_oht;
  logic [WIDTH-1:0] raw_oht;
  logic             msk_any;
  logic             raw_any;
  logic [WIDTH-1:0] sel_oht;
  logic [IDX_W-1:0] sel_idx;

  // On an unlocked transfer, drop the current holder and apply the advanced mask in the same cycle.
  always_comb begin
    xfer    = gnt_vld_q & gnt_rdy;
    locked  = (LOCK != 0) && (|(gnt_oht_q & req_lck & req_vld));
    rearb   = (state_q == BUSY) && xfer && !locked;
    msk_nxt = '0;
    for (int i = 0; i < WIDTH; i++) msk_nxt[i] = (i > int'(gnt_idx_q));
    req_use = rearb ? (req_vld & ~gnt_oht_q) : req_vld;
    msk_use = rearb ? msk_nxt : msk_q;
    req_msk = req_use & msk_use;
  end

  priority_to_onehot_tree #(
    .WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)
  ) u_tree_msk (
    .req(req_msk), .oht(msk_oht), .vld(msk_any)
  );

  priority_to_onehot_tree #(
    .WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)
  ) u_tree_raw (
    .req(req_use), .oht(raw_oht), .vld(raw_any)
  );

  // Masked winner takes precedence; fall back to unmasked when nothing above the pointer requests.
  always_comb begin
    sel_oht = msk_any ? msk_oht : raw_oht;
    sel_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel_oht[i]) sel_idx = sel_idx | IDX_W'(i);
    end
  end

  // Next-state: grant on idle request, hold while busy, re-arbitrate or release on unlocked transfer.
  always_comb begin
    state_d   = state_q;
    msk_d     = msk_q;
    gnt_oht_d = gnt_oht_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    case (state_q)
      IDLE: begin
        if (raw_any) begin
          gnt_oht_d = sel_oht;
          gnt_idx_d = sel_idx;
          gnt_vld_d = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (rearb) begin
          msk_d = msk_nxt;
          if (raw_any) begin
            gnt_oht_d = sel_oht;
            gnt_idx_d = sel_idx;
            gnt_vld_d = 1'b1;
          end else begin
            gnt_oht_d = '0;
            gnt_idx_d = '0;
            gnt_vld_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, mask and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      msk_q     <= '1;
      gnt_oht_q <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      msk_q     <= msk_d;
      gnt_oht_q <= gnt_oht_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
    end
  end

  assign gnt_oht = gnt_oht_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Directed bench for the round-robin arbiter (WIDTH=8 with and without lock) plus a WIDTH=5 random run.
// Latency: grants observed one cycle after the request edge.
// Backpressure: gnt_rdy driven per scenario; sticky requests in the random run.
module tb_priority_arbiter_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_vld;
  logic [7:0] req_lck;
  logic       gnt_rdy;
  logic [7:0] gnt_oht_a, gnt_oht_b;
  logic [2:0] gnt_idx_a, gnt_idx_b;
  logic       gnt_vld_a, gnt_vld_b;

  logic [4:0] req_vld5;
  logic [4:0] req_lck5;
  logic       gnt_rdy5;
  logic [4:0] gnt_oht_c;
  logic [2:0] gnt_idx_c;
  logic       gnt_vld_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  priority_arbiter_rr #(.WIDTH(8), .SPLIT(2), .IMPLEMENTATION(0), .LOCK(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_lck(req_lck),
    .gnt_oht(gnt_oht_a), .gnt_idx(gnt_idx_a), .gnt_vld(gnt_vld_a), .gnt_rdy(gnt_rdy)
  );

  priority_arbiter_rr #(.WIDTH(8), .SPLIT(2), .IMPLEMENTATION(0), .LOCK(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_lck(req_lck),
    .gnt_oht(gnt_oht_b), .gnt_idx(gnt_idx_b), .gnt_vld(gnt_vld_b), .gnt_rdy(gnt_rdy)
  );

  priority_arbiter_rr #(.WIDTH(5), .SPLIT(2), .IMPLEMENTATION(0), .LOCK(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld5), .req_lck(req_lck5),
    .gnt_oht(gnt_oht_c), .gnt_idx(gnt_idx_c), .gnt_vld(gnt_vld_c), .gnt_rdy(gnt_rdy5)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req_vld  = '0;
    req_lck  = '0;
    gnt_rdy  = 1'b0;
    req_vld5 = '0;
    req_lck5 = '0;
    gnt_rdy5 = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int         exp_a[5];
    int         exp_b[5];
    logic [4:0] pend;
    logic [4:0] clr;
    logic [4:0] exp_oht;
    int         cnt[5];
    int         w;

    exp_a = '{1, 1, 1, 1, 3};
    exp_b = '{1, 3, 1, 3, 1};

    // Reset with no requests: nothing granted.
    rst_n = 1'b0;
    req_vld = '0; req_lck = '0; gnt_rdy = 1'b0;
    req_vld5 = '0; req_lck5 = '0; gnt_rdy5 = 1'b0;
    #1;
    check_eq("rst_vld", gnt_vld_a, 0);
    check_eq("rst_oht", gnt_oht_a, 0);
    check_eq("rst_idx", gnt_idx_a, 0);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("idle_vld", gnt_vld_a, 0);
      check_eq("idle_oht", gnt_oht_a, 0);
    end

    // Two requesters at opposite ends alternate with no bubble.
    do_reset();
    req_vld = 8'h81;
    gnt_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("alt_idx", gnt_idx_a, (k % 2) ? 7 : 0);
      check_eq("alt_vld", gnt_vld_a, 1);
    end

    // All requesting: 0..7 then wrap to 0.
    do_reset();
    req_vld = 8'hFF;
    gnt_rdy = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      check_eq("all_idx", gnt_idx_a, k % 8);
      check_eq("all_oht", gnt_oht_a, 32'd1 << (k % 8));
    end

    // Backpressure: grant held 5 cycles, transfer on 6th moves to the next requester.
    do_reset();
    req_vld = 8'h06;
    gnt_rdy = 1'b0;
    tick();
    check_eq("bp_oht0", gnt_oht_a, 8'h02);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("bp_hold", gnt_oht_a, 8'h02);
    end
    gnt_rdy = 1'b1;
    tick();
    check_eq("bp_next_oht", gnt_oht_a, 8'h04);
    check_eq("bp_next_idx", gnt_idx_a, 2);

    // Lock held for three transfers (LOCK=1) versus ignored (LOCK=0).
    do_reset();
    req_vld = 8'h0A;
    req_lck = 8'h02;
    gnt_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) req_lck = 8'h00;
      tick();
      check_eq("lck_idx_a", gnt_idx_a, exp_a[k]);
      check_eq("lck_idx_b", gnt_idx_b, exp_b[k]);
      check_eq("lck_vld_b", gnt_vld_b, 1);
    end

    // Reset while busy on index 5: outputs clear at once, restart from index 0.
    do_reset();
    req_vld = 8'h20;
    req_lck = 8'h20;
    gnt_rdy = 1'b0;
    tick();
    check_eq("mid_idx", gnt_idx_a, 5);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vld", gnt_vld_a, 0);
    check_eq("mid_rst_oht", gnt_oht_a, 0);
    check_eq("mid_rst_idx", gnt_idx_a, 0);
    req_vld = 8'hFF;
    req_lck = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_idx", gnt_idx_a, 0);
    check_eq("post_rst_vld", gnt_vld_a, 1);

    // WIDTH=5 random run with sticky requests: invariants and bounded waiting.
    do_reset();
    pend = '0;
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      check_eq("c_onehot", $onehot(gnt_oht_c), gnt_vld_c);
      exp_oht = gnt_vld_c ? (5'd1 << gnt_idx_c) : 5'd0;
      check_eq("c_oht_idx", gnt_oht_c, exp_oht);
      check_eq("c_gnt_req", gnt_oht_c & ~pend, 0);
      if (!gnt_vld_c) check_eq("c_idx_idle", gnt_idx_c, 0);
      gnt_rdy5 = ($urandom_range(0, 3) != 0);
      clr = '0;
      if (gnt_vld_c && gnt_rdy5) begin
        w = int'(gnt_idx_c);
        if (w < 5) begin
          for (int i = 0; i < 5; i++) begin
            if (pend[i] && i != w) cnt[i]++;
          end
          check_eq("c_wait_le4", (cnt[w] <= 4), 1);
          cnt[w] = 0;
          clr[w] = 1'b1;
        end
      end
      pend = pend | (5'($urandom) & 5'($urandom));
      req_vld5 = pend;
      tick();
      pend = pend & ~clr;
      req_vld5 = pend;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
